// File: rtl/rvfi_retire_serializer_if.sv
// Bundle of the multi-channel RVFI retirement input and the single-channel output
// of rvfi_retire_serializer; master = core/consumer side, slave = serializer.
interface rvfi_retire_serializer_if #(
    parameter int NRET = 2,
    parameter int XLEN = 32
);
    logic [NRET-1:0]      in_valid;
    logic [64*NRET-1:0]   in_order;
    logic [32*NRET-1:0]   in_insn;
    logic [NRET-1:0]      in_trap;
    logic [NRET-1:0]      in_halt;
    logic [NRET-1:0]      in_intr;
    logic [XLEN*NRET-1:0] in_pc_rdata;
    logic [XLEN*NRET-1:0] in_pc_wdata;

    logic                 out_valid;
    logic                 out_ready;
    logic [63:0]          out_order;
    logic [31:0]          out_insn;
    logic                 out_trap;
    logic                 out_halt;
    logic                 out_intr;
    logic [XLEN-1:0]      out_pc_rdata;
    logic [XLEN-1:0]      out_pc_wdata;
    logic                 overflow;
    logic                 order_err;

    modport master (
        output in_valid, in_order, in_insn, in_trap, in_halt, in_intr,
               in_pc_rdata, in_pc_wdata, out_ready,
        input  out_valid, out_order, out_insn, out_trap, out_halt, out_intr,
               out_pc_rdata, out_pc_wdata, overflow, order_err
    );

    modport slave (
        input  in_valid, in_order, in_insn, in_trap, in_halt, in_intr,
               in_pc_rdata, in_pc_wdata, out_ready,
        output out_valid, out_order, out_insn, out_trap, out_halt, out_intr,
               out_pc_rdata, out_pc_wdata, overflow, order_err
    );
endinterface

// File: rtl/rvfi_retire_serializer.sv
// Serializes up to NRET RVFI retirements per cycle into a one-per-cycle stream via a FIFO.
// Optional order-continuity checker enabled by defining RVFI_SERIALIZER_ORDER_CHECK_EN.
module rvfi_retire_serializer #(
    parameter int NRET  = 2,
    parameter int XLEN  = 32,
    parameter int DEPTH = 8
) (
    input logic                    clock,
    input logic                    reset,
    rvfi_retire_serializer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [63:0]     order;
        logic [31:0]     insn;
        logic            trap;
        logic            halt;
        logic            intr;
        logic [XLEN-1:0] pc_rdata;
        logic [XLEN-1:0] pc_wdata;
    } entry_t;

    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] slot;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [CW-1:0] npush;
    logic          accept;
    logic          pop;
    entry_t        head;

    function automatic logic [CW-1:0] popcount(input logic [NRET-1:0] v);
        logic [CW-1:0] n;
        n = '0;
        for (int k = 0; k < NRET; k++) n = n + CW'(v[k]);
        return n;
    endfunction

    // Acceptance uses the occupancy at the start of the cycle; a same-cycle pop frees nothing.
    always_comb begin
        npush  = popcount(bus.in_valid);
        accept = (CW'(DEPTH) - count_q) >= npush;
        head   = mem_q[rd_ptr_q];
        pop    = bus.out_valid && bus.out_ready;
    end

    // Valid channels pack into consecutive slots, lowest channel (oldest) first.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        slot     = wr_ptr_q;
        if (accept && !reset) begin
            for (int k = 0; k < NRET; k++) begin
                if (bus.in_valid[k]) begin
                    mem_d[slot].order    = bus.in_order[64*k +: 64];
                    mem_d[slot].insn     = bus.in_insn[32*k +: 32];
                    mem_d[slot].trap     = bus.in_trap[k];
                    mem_d[slot].halt     = bus.in_halt[k];
                    mem_d[slot].intr     = bus.in_intr[k];
                    mem_d[slot].pc_rdata = bus.in_pc_rdata[XLEN*k +: XLEN];
                    mem_d[slot].pc_wdata = bus.in_pc_wdata[XLEN*k +: XLEN];
                    slot                 = slot + PW'(1);
                end
            end
            wr_ptr_d = slot;
        end
    end

    always_comb begin
        rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d    = count_q + (accept ? npush : '0) - CW'(pop);
        overflow_d = overflow_q | !accept;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage carries no reset; occupancy alone decides what is live.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    assign bus.out_valid    = (count_q != '0) && !reset;
    assign bus.out_order    = head.order;
    assign bus.out_insn     = head.insn;
    assign bus.out_trap     = head.trap;
    assign bus.out_halt     = head.halt;
    assign bus.out_intr     = head.intr;
    assign bus.out_pc_rdata = head.pc_rdata;
    assign bus.out_pc_wdata = head.pc_wdata;
    assign bus.overflow     = overflow_q;

`ifdef RVFI_SERIALIZER_ORDER_CHECK_EN
    logic [63:0] exp_order_q, exp_order_d;
    logic        seen_q, seen_d;
    logic        order_err_q, order_err_d;

    // The first pop after reset only seeds the expected order.
    always_comb begin
        exp_order_d = exp_order_q;
        seen_d      = seen_q;
        order_err_d = order_err_q;
        if (pop) begin
            if (seen_q && (head.order != exp_order_q)) order_err_d = 1'b1;
            exp_order_d = head.order + 64'd1;
            seen_d      = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            exp_order_q <= '0;
            seen_q      <= 1'b0;
            order_err_q <= 1'b0;
        end else begin
            exp_order_q <= exp_order_d;
            seen_q      <= seen_d;
            order_err_q <= order_err_d;
        end
    end

    assign bus.order_err = order_err_q;
`else
    assign bus.order_err = 1'b0;
`endif
endmodule
